// File: rtl/buffer_write_back.sv
// Write-back buffer between L2 and main memory: queues dirty victims in a small FIFO,
// coalesces repeated addresses, serves L2 misses from pending entries and drains to memory.
module buffer_write_back #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    evict_valid,
  input  logic [ADDR_WIDTH-1:0]   evict_address,
  input  logic [DATA_WIDTH-1:0]   evict_data,
  output logic                    evict_ready,
  input  logic [ADDR_WIDTH-1:0]   lookup_address,
  output logic                    lookup_hit,
  output logic [DATA_WIDTH-1:0]   lookup_data,
  input  logic                    mem_busy,
  output logic                    mem_wren,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StPop} state_t;

  state_t                  state;
  logic [LW-1:0]           lat;
  logic                    flushing;

  logic [DEPTH-1:0]        valid;
  logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;

  logic                    start_drain;
  logic                    inflight;
  logic                    push;
  logic                    pop;
  logic                    co_hit;
  logic [PW-1:0]           co_idx;
  logic [PW-1:0]           co_scan;
  logic [PW-1:0]           lk_scan;
  logic [CW-1:0]           count_d;
  logic                    flush_fire;

  assign evict_ready = (count < CW'(DEPTH));
  assign empty       = (count == '0);
  assign start_drain = (state == StIdle) && !empty && !mem_busy;
  // The head is owned by the memory write from the edge that starts it until it is popped.
  assign inflight    = (state != StIdle) || start_drain;
  assign push        = evict_valid && evict_ready;
  assign pop         = (state == StPop);
  assign flush_fire  = flushing && empty && (state == StIdle);

  // Coalesce target: newest valid match that is not the in-flight head.
  always_comb begin
    co_hit  = 1'b0;
    co_idx  = '0;
    co_scan = '0;
    for (int i = 0; i < DEPTH; i++) begin
      co_scan = head + PW'(i);
      if (valid[co_scan] && (addr_q[co_scan] == evict_address) &&
          !(inflight && (co_scan == head))) begin
        co_hit = 1'b1;
        co_idx = co_scan;
      end
    end
  end

  // Scan oldest to newest so the newest match overrides.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_scan     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_scan = head + PW'(i);
      if (valid[lk_scan] && (addr_q[lk_scan] == lookup_address)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lk_scan];
      end
    end
  end

  always_comb begin
    count_d = count;
    if (push && !co_hit) begin
      count_d = count_d + CW'(1);
    end
    if (pop) begin
      count_d = count_d - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count <= count_d;
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        if (co_hit) begin
          data_q[co_idx] <= evict_data;
        end else begin
          valid[tail]  <= 1'b1;
          addr_q[tail] <= evict_address;
          data_q[tail] <= evict_data;
          tail         <= tail + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      lat         <= '0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      flushing    <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      flush_done <= flush_fire;
      if (flush_fire) begin
        flushing <= 1'b0;
      end else if (flush) begin
        flushing <= 1'b1;
      end
      case (state)
        StIdle: begin
          if (start_drain) begin
            state       <= StWrite;
            mem_wren    <= 1'b1;
            mem_address <= addr_q[head];
            mem_data    <= data_q[head];
            lat         <= LW'(MEM_LATENCY - 1);
          end
        end
        StWrite: begin
          if (lat == '0) begin
            state    <= StPop;
            mem_wren <= 1'b0;
          end else begin
            lat <= lat - LW'(1);
          end
        end
        StPop: begin
          state <= StIdle;
        end
        default: begin
          state    <= StIdle;
          mem_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_write_back.sv
// Directed self-checking bench for buffer_write_back with a memory-write monitor.
module tb_buffer_write_back;

  logic        clock = 1'b0;
  logic        reset;
  logic        evict_valid;
  logic [5:0]  evict_address;
  logic [15:0] evict_data;
  logic        evict_ready;
  logic [5:0]  lookup_address;
  logic        lookup_hit;
  logic [15:0] lookup_data;
  logic        mem_busy;
  logic        mem_wren;
  logic [5:0]  mem_address;
  logic [15:0] mem_data;
  logic        flush;
  logic        flush_done;
  logic [2:0]  count;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0]  wq_addr [$];
  logic [15:0] wq_data [$];
  int          wq_len  [$];
  int          run_len = 0;
  int          bad_stable = 0;
  logic        wr_prev = 1'b0;
  logic [5:0]  run_addr;
  logic [15:0] run_data;

  int pulses;
  int pulse_at;

  buffer_write_back dut (
    .clock          (clock),
    .reset          (reset),
    .evict_valid    (evict_valid),
    .evict_address  (evict_address),
    .evict_data     (evict_data),
    .evict_ready    (evict_ready),
    .lookup_address (lookup_address),
    .lookup_hit     (lookup_hit),
    .lookup_data    (lookup_data),
    .mem_busy       (mem_busy),
    .mem_wren       (mem_wren),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .flush          (flush),
    .flush_done     (flush_done),
    .count          (count),
    .empty          (empty)
  );

  always #5 clock = ~clock;

  // Record every memory write burst: address, data and strobe length.
  initial forever begin
    @(negedge clock);
    if (mem_wren && !wr_prev) begin
      wq_addr.push_back(mem_address);
      wq_data.push_back(mem_data);
      run_addr = mem_address;
      run_data = mem_data;
      run_len  = 1;
    end else if (mem_wren) begin
      run_len++;
      if (mem_address !== run_addr || mem_data !== run_data) bad_stable++;
    end
    if (!mem_wren && wr_prev) wq_len.push_back(run_len);
    wr_prev = mem_wren;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed no finish required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [15:0] d);
    evict_valid   = 1'b1;
    evict_address = a;
    evict_data    = d;
    tick();
    evict_valid   = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60; i++) begin
      if (empty) break;
      tick();
    end
    chk("drain_done", empty, 1);
  endtask

  task automatic expect_write(input logic [5:0] a, input logic [15:0] d);
    chk("wr_present", wq_addr.size() > 0, 1);
    if (wq_addr.size() > 0) begin
      chk("wr_addr", wq_addr.pop_front(), a);
      chk("wr_data", wq_data.pop_front(), d);
    end
    chk("wr_len_present", wq_len.size() > 0, 1);
    if (wq_len.size() > 0) chk("wr_len", wq_len.pop_front(), 2);
  endtask

  initial begin
    reset = 1'b1;
    evict_valid = 1'b0;
    evict_address = '0;
    evict_data = '0;
    lookup_address = '0;
    mem_busy = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", evict_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_wren", mem_wren, 0);
    chk("rst_count", count, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_fdone", flush_done, 0);
    chk("rst_maddr", mem_address, 0);
    reset = 1'b0;
    tick();

    // Single entry held by mem_busy, then drained.
    mem_busy = 1'b1;
    lookup_address = 6'd18;
    push(6'd18, 16'd19);
    repeat (4) tick();
    chk("busy_count", count, 1);
    chk("busy_wren", mem_wren, 0);
    chk("busy_hit", lookup_hit, 1);
    chk("busy_ldata", lookup_data, 19);
    mem_busy = 1'b0;
    tick();
    chk("w1_wren", mem_wren, 1);
    chk("w1_addr", mem_address, 18);
    chk("w1_data", mem_data, 19);
    tick();
    chk("w2_wren", mem_wren, 1);
    tick();
    chk("pop_wren", mem_wren, 0);
    chk("pop_hit", lookup_hit, 1);
    chk("pop_count", count, 1);
    tick();
    chk("idle_count", count, 0);
    chk("idle_hit", lookup_hit, 0);
    chk("idle_ldata", lookup_data, 0);
    chk("hold_addr", mem_address, 18);
    expect_write(6'd18, 16'd19);

    // Fill to full; fifth push held until the first pop.
    mem_busy = 1'b1;
    push(6'd3, 16'd8);
    push(6'd9, 16'd10);
    push(6'd11, 16'd12);
    push(6'd27, 16'd28);
    chk("full_count", count, 4);
    chk("full_ready", evict_ready, 0);
    evict_valid = 1'b1;
    evict_address = 6'd31;
    evict_data = 16'd32;
    mem_busy = 1'b0;
    repeat (3) tick();
    chk("full_pop_ready", evict_ready, 0);
    chk("full_pop_count", count, 4);
    tick();
    chk("after_pop_count", count, 3);
    chk("after_pop_ready", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    chk("held_push_count", count, 4);
    chk("next_wren", mem_wren, 1);
    chk("next_addr", mem_address, 9);
    wait_empty();
    expect_write(6'd3, 16'd8);
    expect_write(6'd9, 16'd10);
    expect_write(6'd11, 16'd12);
    expect_write(6'd27, 16'd28);
    expect_write(6'd31, 16'd32);

    // Coalesce in place, but never into the in-flight head.
    mem_busy = 1'b1;
    lookup_address = 6'd12;
    push(6'd12, 16'd13);
    push(6'd12, 16'd14);
    chk("coal_count", count, 1);
    chk("coal_ldata", lookup_data, 14);
    mem_busy = 1'b0;
    tick();
    chk("coal_mdata", mem_data, 14);
    push(6'd12, 16'd15);
    chk("nocoal_count", count, 2);
    chk("nocoal_ldata", lookup_data, 15);
    wait_empty();
    expect_write(6'd12, 16'd14);
    expect_write(6'd12, 16'd15);

    // Newest match wins over the in-flight head.
    mem_busy = 1'b1;
    push(6'd5, 16'd1);
    mem_busy = 1'b0;
    tick();
    push(6'd5, 16'd2);
    lookup_address = 6'd5;
    #1;
    chk("prio_hit", lookup_hit, 1);
    chk("prio_ldata", lookup_data, 2);
    lookup_address = 6'd6;
    #1;
    chk("miss_hit", lookup_hit, 0);
    chk("miss_ldata", lookup_data, 0);
    wait_empty();
    expect_write(6'd5, 16'd1);
    expect_write(6'd5, 16'd2);

    // Flush with three entries queued.
    mem_busy = 1'b1;
    push(6'd40, 16'd1);
    push(6'd41, 16'd2);
    push(6'd42, 16'd3);
    chk("fl_count", count, 3);
    mem_busy = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_early", flush_done, 0);
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (flush_done) begin
        pulses++;
        if (pulse_at == 0) pulse_at = i;
        chk("fl_done_empty", empty, 1);
      end
    end
    chk("fl_pulses", pulses, 1);
    chk("fl_pulse_at", pulse_at, 12);
    expect_write(6'd40, 16'd1);
    expect_write(6'd41, 16'd2);
    expect_write(6'd42, 16'd3);

    // Flush while empty.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fe_first", flush_done, 0);
    tick();
    chk("fe_pulse", flush_done, 1);
    tick();
    chk("fe_after", flush_done, 0);
    chk("stable", bad_stable, 0);

    // Reset in the middle of a write.
    lookup_address = 6'd50;
    push(6'd50, 16'd7);
    tick();
    chk("mid_wren", mem_wren, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wren", mem_wren, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_hit", lookup_hit, 0);
    chk("mid_rst_ready", evict_ready, 1);
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_wren", mem_wren, 0);
    chk("post_rst_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
